counter_updown_mod_sync: RTL and testbench
==========================================

// Module: counter_updown_mod_sync
// PURPOSE
//  Parametrised synchronous up/down modulo counter; next generation of the 4-bit ripple down counter.
//  Single clock, all flops on rising Clk (no rippled clocks), WIDTH/MODULUS configurable.
//  Adds count enable, run-time direction, parallel load, terminal-count and wrap indication.
//  Used as a timebase/divider and event counter inside datapath and display blocks.
// PARAMETERS
//  WIDTH    4          counter width in bits, 1..32
//  MODULUS  2**WIDTH   count range 0..MODULUS-1; legal 2..2**WIDTH (elaboration error otherwise)
// PORTS
//  Clk      in   1      clock; all state updates on rising edge
//  Clr      in   1      synchronous reset, active-high
//  En       in   1      count enable; holds value when low
//  Up       in   1      direction: 1 = up, 0 = down
//  Load     in   1      synchronous parallel load
//  LoadVal  in   WIDTH  value loaded when Load=1
//  count    out  WIDTH  registered counter value
//  tc       out  1      combinational terminal count: En & ((Up & count==MODULUS-1) | (~Up & count==0))
//  wrap     out  1      registered one-cycle pulse: the previous edge crossed the terminal value
// BEHAVIOUR
//  - One clock, one reset. Reset is synchronous, active-high.
//  - Priority at each rising Clk edge: Clr > Load > En. Up is sampled only when En=1 and Load=0.
//  - Clr=1: count<=0 and wrap<=0. tc then follows its equation; with Up=0 and En=1, tc=1 directly after reset.
//  - Load=1: count<=LoadVal and wrap<=0. LoadVal>=MODULUS is clamped to MODULUS-1. Load overrides En.
//  - En=1, Up=1: count<=count+1. At MODULUS-1, count<=0 and wrap<=1.
//  - En=1, Up=0: count<=count-1. At 0, count<=MODULUS-1 and wrap<=1.
//  - En=0 (no Clr, no Load): count holds and wrap<=0.
//  - Latency: count changes 1 cycle after the qualifying edge. wrap is high for exactly the cycle after the wrap edge.
//  - tc is purely combinational from count, Up and En. It has no flop and is meant for cascading
//    (upper stage En = lower stage tc).
//  - Direction change at a boundary: evaluated with the new Up. Example: count=0, Up flips 1->0 with En=1 -> wraps to MODULUS-1.
//  - Non-power-of-2 MODULUS: count never leaves 0..MODULUS-1, even after a load (clamp).
//  - Arithmetic is done in WIDTH bits. When MODULUS==2**WIDTH, natural overflow gives the same result as the explicit wrap.
//  - Reset mid-count: takes effect on the next edge regardless of En/Load/Up. No partial state is kept.
// CONFIGURATION
//  COUNTER_UPDOWN_MOD_SYNC_SAT_EN
//   - Defined: saturating mode. Up at MODULUS-1 holds at MODULUS-1; down at 0 holds at 0.
//     wrap then pulses 1 cycle for each attempted step past the limit (overflow/underflow flag).
//     tc is unchanged.
//   - Undefined (default): modulo wrap-around as described above.
//   - Load, Clr and priority are identical in both modes.
// TESTING  (WIDTH=4, MODULUS=10 unless noted)
//  1. Clr=1 for 2 cycles with En=1 -> count=0, wrap=0. Release with Up=1 -> 1,2,...,9 on successive edges, tc=1 while count=9.
//  2. Up=1, En=1 from count=9 -> count=0 and wrap=1 for exactly one cycle. Up=0 from count=0 -> count=9, wrap pulse.
//  3. Load=1, LoadVal=7, En=1 -> count=7 (load wins). LoadVal=13 -> count=9 (clamped). Load and Clr together -> count=0.
//  4. En toggled 1,0,0,1 with Up=1 from 3 -> 4,4,4,5. tc=0 whenever En=0, even at count=9.
//  5. Two instances cascaded (upper En = lower tc), 100 edges from reset -> {upper,lower} reads 0,0 with one upper wrap pulse.
//  6. With COUNTER_UPDOWN_MOD_SYNC_SAT_EN, up from 9 for 3 edges -> count stays 9, wrap=1 each cycle.
//     Default WIDTH=4/MODULUS=16, down from 0 -> 15.

Source files
------------

// File: rtl/counter_updown_mod_sync_if.sv
// counter_updown_mod_sync_if
//   Control/status bundle for counter_updown_mod_sync.
//   master : the block that steers the counter (drives En/Up/Load/LoadVal).
//   slave  : the counter itself (drives count/tc/wrap).
//   Signals:
//     En      count enable
//     Up      direction, 1 = up, 0 = down
//     Load    synchronous parallel load
//     LoadVal value loaded when Load=1 (WIDTH bits)
//     count   registered counter value (WIDTH bits)
//     tc      combinational terminal count
//     wrap    registered one-cycle wrap/limit pulse
interface counter_updown_mod_sync_if #(
    parameter int unsigned WIDTH = 4
);
    logic             En;
    logic             Up;
    logic             Load;
    logic [WIDTH-1:0] LoadVal;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;

    modport master (
        output En, Up, Load, LoadVal,
        input  count, tc, wrap
    );

    modport slave (
        input  En, Up, Load, LoadVal,
        output count, tc, wrap
    );
endinterface

// File: rtl/counter_updown_mod_sync.sv
// counter_updown_mod_sync
//   Synchronous up/down modulo counter, WIDTH bits, range 0..MODULUS-1.
//   All state updates on rising Clk. Priority per edge: Clr > Load > En.
//   Ports:
//     Clk  clock
//     Clr  synchronous reset, active-high (count<=0, wrap<=0)
//     bus  counter_updown_mod_sync_if.slave: En, Up, Load, LoadVal in;
//          count, tc, wrap out. Interface WIDTH must match the module WIDTH.
//   Configuration macro:
//     COUNTER_UPDOWN_MOD_SYNC_SAT_EN  defined   -> saturate at 0 / MODULUS-1,
//                                                 wrap flags each blocked step
//                                     undefined -> modulo wrap-around
module counter_updown_mod_sync #(
    parameter int unsigned     WIDTH   = 4,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
    input logic                       Clk,
    input logic                       Clr,
    counter_updown_mod_sync_if.slave  bus
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("counter_updown_mod_sync: WIDTH must be 1..32");
    end
    if (MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
        $error("counter_updown_mod_sync: MODULUS must be 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic             wrap_q;
    logic [WIDTH-1:0] load_clamped;
    logic             at_max;
    logic             at_min;

    assign at_max = (count_q == MAXV);
    assign at_min = (count_q == '0);

    // Out-of-range load values are pinned to the top of the range so the
    // count never leaves 0..MODULUS-1 with a non-power-of-2 modulus.
    always_comb begin
        load_clamped = bus.LoadVal;
        if (64'(bus.LoadVal) > 64'(MAXV)) begin
            load_clamped = MAXV;
        end
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else if (bus.Load) begin
            count_q <= load_clamped;
            wrap_q  <= 1'b0;
        end else if (bus.En) begin
            if (bus.Up) begin
                if (at_max) begin
`ifdef COUNTER_UPDOWN_MOD_SYNC_SAT_EN
                    count_q <= count_q;
`else
                    count_q <= '0;
`endif
                    wrap_q  <= 1'b1;
                end else begin
                    count_q <= count_q + ONE;
                    wrap_q  <= 1'b0;
                end
            end else begin
                if (at_min) begin
`ifdef COUNTER_UPDOWN_MOD_SYNC_SAT_EN
                    count_q <= count_q;
`else
                    count_q <= MAXV;
`endif
                    wrap_q  <= 1'b1;
                end else begin
                    count_q <= count_q - ONE;
                    wrap_q  <= 1'b0;
                end
            end
        end else begin
            wrap_q <= 1'b0;
        end
    end

    assign bus.count = count_q;
    assign bus.wrap  = wrap_q;
    // Unregistered so a following stage can use it directly as its enable.
    assign bus.tc    = bus.En & ((bus.Up & at_max) | (~bus.Up & at_min));

endmodule

// File: tb/tb_counter_updown_mod_sync.sv
module tb_counter_updown_mod_sync;

`ifdef COUNTER_UPDOWN_MOD_SYNC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;

    // Main DUT: WIDTH=4, MODULUS=10
    logic clr;
    counter_updown_mod_sync_if #(.WIDTH(4)) m_if ();
    counter_updown_mod_sync #(.WIDTH(4), .MODULUS(10)) dut (
        .Clk (Clk),
        .Clr (clr),
        .bus (m_if.slave)
    );

    // Default-parameter instance: WIDTH=4, MODULUS=16
    logic clr_d;
    counter_updown_mod_sync_if #(.WIDTH(4)) d_if ();
    counter_updown_mod_sync dut_def (
        .Clk (Clk),
        .Clr (clr_d),
        .bus (d_if.slave)
    );

    // Cascade: upper stage enabled by lower stage tc
    logic clr_c;
    counter_updown_mod_sync_if #(.WIDTH(4)) lo_if ();
    counter_updown_mod_sync_if #(.WIDTH(4)) hi_if ();
    counter_updown_mod_sync #(.WIDTH(4), .MODULUS(10)) dut_lo (
        .Clk (Clk),
        .Clr (clr_c),
        .bus (lo_if.slave)
    );
    counter_updown_mod_sync #(.WIDTH(4), .MODULUS(10)) dut_hi (
        .Clk (Clk),
        .Clr (clr_c),
        .bus (hi_if.slave)
    );
    assign hi_if.En = lo_if.tc;

    typedef struct {
        logic       clr;
        logic       load;
        logic       en;
        logic       up;
        logic [3:0] lv;
        logic [3:0] c;
        logic       w;
        logic       t;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic clr_i, input logic load_i, input logic en_i,
                       input logic up_i, input int lv_i, input int c_i,
                       input logic w_i, input logic t_i);
        vec_t v;
        v.clr  = clr_i;
        v.load = load_i;
        v.en   = en_i;
        v.up   = up_i;
        v.lv   = 4'(lv_i);
        v.c    = 4'(c_i);
        v.w    = w_i;
        v.t    = t_i;
        vq.push_back(v);
    endtask

    task automatic drive_main(input logic c, input logic ld, input logic e,
                              input logic u, input logic [3:0] lv);
        @(negedge Clk);
        clr          = c;
        m_if.Load    = ld;
        m_if.En      = e;
        m_if.Up      = u;
        m_if.LoadVal = lv;
        @(posedge Clk);
        #1;
    endtask

    int hi_wraps;

    initial begin
        clr          = 1'b0;
        m_if.En      = 1'b0;
        m_if.Up      = 1'b1;
        m_if.Load    = 1'b0;
        m_if.LoadVal = '0;
        clr_d        = 1'b0;
        d_if.En      = 1'b0;
        d_if.Up      = 1'b1;
        d_if.Load    = 1'b0;
        d_if.LoadVal = '0;
        clr_c        = 1'b0;
        lo_if.En     = 1'b1;
        lo_if.Up     = 1'b1;
        lo_if.Load   = 1'b0;
        lo_if.LoadVal = '0;
        hi_if.Up     = 1'b1;
        hi_if.Load   = 1'b0;
        hi_if.LoadVal = '0;

        //   clr load en up lv  count           wrap           tc
        add(1, 0, 1, 1, 0,  0,               0,             0);
        add(1, 0, 1, 1, 0,  0,               0,             0);
        for (int k = 1; k <= 9; k++)
            add(0, 0, 1, 1, 0, k, 0, (k == 9));
        add(0, 0, 1, 1, 0,  SAT ? 9 : 0,     1,             SAT);
        add(1, 0, 1, 0, 0,  0,               0,             1);
        add(0, 0, 1, 0, 0,  SAT ? 0 : 9,     1,             SAT);
        add(0, 0, 1, 0, 0,  SAT ? 0 : 8,     SAT,           SAT);
        add(0, 1, 1, 1, 7,  7,               0,             0);
        add(0, 1, 1, 1, 13, 9,               0,             1);
        add(1, 1, 1, 1, 5,  0,               0,             0);
        add(0, 1, 0, 1, 3,  3,               0,             0);
        add(0, 0, 1, 1, 0,  4,               0,             0);
        add(0, 0, 0, 1, 0,  4,               0,             0);
        add(0, 0, 0, 1, 0,  4,               0,             0);
        add(0, 0, 1, 1, 0,  5,               0,             0);
        add(0, 1, 0, 1, 9,  9,               0,             0);
        add(0, 0, 0, 1, 0,  9,               0,             0);
        add(0, 1, 1, 1, 0,  0,               0,             0);
        add(0, 0, 1, 0, 0,  SAT ? 0 : 9,     1,             SAT);
        add(0, 1, 0, 1, 15, 9,               0,             0);

        for (int i = 0; i < vq.size(); i++) begin
            drive_main(vq[i].clr, vq[i].load, vq[i].en, vq[i].up, vq[i].lv);
            check($sformatf("v%0d.count", i), int'(m_if.count), int'(vq[i].c));
            check($sformatf("v%0d.wrap", i),  int'(m_if.wrap),  int'(vq[i].w));
            check($sformatf("v%0d.tc", i),    int'(m_if.tc),    int'(vq[i].t));
        end

        // Three up steps from the top of the range
        drive_main(0, 1, 1, 1, 4'd9);
        check("top.count", int'(m_if.count), 9);
        for (int i = 0; i < 3; i++) begin
            drive_main(0, 0, 1, 1, 4'd0);
            check($sformatf("top%0d.count", i), int'(m_if.count), SAT ? 9 : i);
            check($sformatf("top%0d.wrap", i),  int'(m_if.wrap),  (SAT || i == 0) ? 1 : 0);
        end

        // Default-parameter instance: down from 0, then up from the top
        @(negedge Clk);
        clr_d = 1'b1; d_if.En = 1'b1; d_if.Up = 1'b0;
        @(posedge Clk); #1;
        check("def.rst.count", int'(d_if.count), 0);
        check("def.rst.tc",    int'(d_if.tc),    1);
        @(negedge Clk);
        clr_d = 1'b0;
        @(posedge Clk); #1;
        check("def.down.count", int'(d_if.count), SAT ? 0 : 15);
        check("def.down.wrap",  int'(d_if.wrap),  1);
        @(negedge Clk);
        d_if.Up = 1'b1;
        @(posedge Clk); #1;
        check("def.up.count", int'(d_if.count), SAT ? 1 : 0);
        check("def.up.wrap",  int'(d_if.wrap),  SAT ? 0 : 1);

`ifndef COUNTER_UPDOWN_MOD_SYNC_SAT_EN
        // Two-stage decade cascade: 100 edges brings both stages back to 0
        @(negedge Clk);
        clr_c = 1'b1;
        @(posedge Clk); #1;
        check("casc.rst", {28'd0, hi_if.count} * 10 + int'(lo_if.count), 0);
        @(negedge Clk);
        clr_c = 1'b0;
        hi_wraps = 0;
        for (int e = 1; e <= 100; e++) begin
            @(posedge Clk); #1;
            if (hi_if.wrap) hi_wraps++;
            if (e == 55)
                check("casc.mid", int'(hi_if.count) * 10 + int'(lo_if.count), 55);
        end
        check("casc.lo",    int'(lo_if.count), 0);
        check("casc.hi",    int'(hi_if.count), 0);
        check("casc.hiwrap.now", int'(hi_if.wrap), 1);
        check("casc.hiwrap.cnt", hi_wraps, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
